dffsn_preset_seq: RTL and testbench

- Sequences active-low set pulses (SN) to NGRP groups of set-able, negative-edge-clocked flops.
- Pulses are staggered to bound simultaneous-set current.
- Holds a clock-enable low around the whole sequence, so no group sees a CLKN edge while its SN is asserted.
- Sits between the power-on/mode controller (START/DONE handshake) and the flop bank's SN pins and CLKN gate.

---
 rtl/dffsn_preset_seq.sv | 173 +++++++++++++++++
 tb/tb_dffsn_preset_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dffsn_preset_seq.sv
// dffsn_preset_seq: staggers active-low set pulses (SN) across NGRP flop groups.
// CKEN (the bank's CLKN gate) is held low from one cycle before the first pulse
// to one cycle after the last. Every output comes straight from a flop.
// Optional feature macro: DFFSN_PRESET_SEQ_MASK_EN adds a MASK input. The mask
// is captured on START, and groups whose mask bit is 0 are skipped.
// Handshake: START is a request that is only looked at in IDLE. BUSY is high
// while a sequence is running. DONE is a single-cycle pulse in FIN. A START
// seen while BUSY=1, or while in FIN, is dropped and never queued.
module dffsn_preset_seq #(
  parameter int NGRP = 4,
  parameter int PW   = 3,
  parameter int GAP  = 2
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            START,
`ifdef DFFSN_PRESET_SEQ_MASK_EN
  input  logic [NGRP-1:0] MASK,
`endif
  output logic [NGRP-1:0] SN,
  output logic            CKEN,
  output logic            BUSY,
  output logic            DONE,
  output logic [2:0]      dbg_state
);

  localparam int CMAX = (PW > GAP) ? PW : GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int GW   = $clog2(NGRP + 1);
  localparam logic [CW-1:0] PW_LAST  = CW'(PW - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GUARD_PRE  = 3'd1,
    S_PULSE      = 3'd2,
    S_GAP        = 3'd3,
    S_GUARD_POST = 3'd4,
    S_FIN        = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NGRP-1:0] sn_q, sn_d;
  logic            cken_q, cken_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NGRP-1:0] mask_eff;
  logic [GW:0]     first_grp, after_grp;

`ifdef DFFSN_PRESET_SEQ_MASK_EN
  logic [NGRP-1:0] mask_q, mask_d;
  assign mask_eff = mask_q;
`else
  assign mask_eff = {NGRP{1'b1}};
`endif

  // Returns {found, index}: the lowest enabled group whose index is >= from.
  function automatic logic [GW:0] next_grp(input logic [NGRP-1:0] m, input int from);
    logic          found;
    logic [GW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = NGRP - 1; i >= 0; i--) begin
      if (i >= from && m[i]) begin
        found = 1'b1;
        idx   = GW'(i);
      end
    end
    return {found, idx};
  endfunction

  // Next-state logic, plus the next value of every registered output.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
`ifdef DFFSN_PRESET_SEQ_MASK_EN
    mask_d    = mask_q;
`endif
    first_grp = next_grp(mask_eff, 0);
    after_grp = next_grp(mask_eff, int'(g_q) + 1);
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_GUARD_PRE;
          g_d     = '0;
          cnt_d   = '0;
`ifdef DFFSN_PRESET_SEQ_MASK_EN
          mask_d  = MASK;
`endif
        end
      end
      S_GUARD_PRE: begin
        cnt_d = '0;
        if (first_grp[GW]) begin
          state_d = S_PULSE;
          g_d     = first_grp[GW-1:0];
        end else begin
          state_d = S_GUARD_POST;
        end
      end
      S_PULSE: begin
        if (cnt_q == PW_LAST) begin
          cnt_d = '0;
          if (!after_grp[GW]) begin
            state_d = S_GUARD_POST;
          end else begin
            // The group index advances on entry to GAP; SN stays high throughout GAP anyway.
            g_d     = after_grp[GW-1:0];
            state_d = (GAP > 0) ? S_GAP : S_PULSE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GUARD_POST: state_d = S_FIN;
      S_FIN:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    for (int i = 0; i < NGRP; i++) begin
      sn_d[i] = !(state_d == S_PULSE && g_d == GW'(i));
    end
    cken_d = (state_d == S_IDLE) || (state_d == S_FIN);
    busy_d = (state_d == S_GUARD_PRE) || (state_d == S_PULSE) ||
             (state_d == S_GAP) || (state_d == S_GUARD_POST);
    done_d = (state_d == S_FIN);
  end

  // State, counters and output registers. Reset aborts any sequence at once.
  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      cnt_q   <= '0;
      sn_q    <= {NGRP{1'b1}};
      cken_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DFFSN_PRESET_SEQ_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      sn_q    <= sn_d;
      cken_q  <= cken_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DFFSN_PRESET_SEQ_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign SN        = sn_q;
  assign CKEN      = cken_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dffsn_preset_seq.sv
// Testbench for dffsn_preset_seq: table-driven cycle checks on the default
// build and on a PW=1/GAP=0 build, plus hand-written reset/abort sequences.
module tb_dffsn_preset_seq;

  typedef struct {
    int         lo;
    int         hi;
    logic [3:0] sn;
    logic       cken;
    logic       busy;
    logic       done;
  } row_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r;
  logic       start, start_f;
  logic [3:0] sn, sn_f;
  logic       cken, busy, done, cken_f, busy_f, done_f;
  logic [2:0] st, st_f;
`ifdef DFFSN_PRESET_SEQ_MASK_EN
  logic [3:0] mask;
`endif

  dffsn_preset_seq u_dut (
    .CLK(clk), .R(r), .START(start),
`ifdef DFFSN_PRESET_SEQ_MASK_EN
    .MASK(mask),
`endif
    .SN(sn), .CKEN(cken), .BUSY(busy), .DONE(done), .dbg_state(st)
  );

  dffsn_preset_seq #(.NGRP(4), .PW(1), .GAP(0)) u_fast (
    .CLK(clk), .R(r), .START(start_f),
`ifdef DFFSN_PRESET_SEQ_MASK_EN
    .MASK(4'hF),
`endif
    .SN(sn_f), .CKEN(cken_f), .BUSY(busy_f), .DONE(done_f), .dbg_state(st_f)
  );

  int n_chk  = 0;
  int n_fail = 0;
  row_t tab_main[11];
  row_t tab_fast[8];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fires START so that it is sampled at the next edge (edge t); returns at cycle t+1.
  task automatic pulse_start(input bit fast);
    if (fast) start_f = 1'b1; else start = 1'b1;
    step();
    start = 1'b0;
    start_f = 1'b0;
  endtask

  // Walks a sequence cycle by cycle from t+1 and checks it against a table.
  // Extra START requests are raised in cycles x1 and x2 and must be ignored.
  task automatic run_table(input bit fast, input int last, input int x1, input int x2, input string tag);
    row_t       rw;
    logic [3:0] a_sn;
    logic       a_ck, a_bz, a_dn;
    bit         hit;
    pulse_start(fast);
    for (int k = 1; k <= last; k++) begin
      hit = 0;
      rw  = '{0, 0, 4'hF, 1'b1, 1'b0, 1'b0};
      if (fast) begin
        foreach (tab_fast[i]) if (!hit && k >= tab_fast[i].lo && k <= tab_fast[i].hi) begin rw = tab_fast[i]; hit = 1; end
      end else begin
        foreach (tab_main[i]) if (!hit && k >= tab_main[i].lo && k <= tab_main[i].hi) begin rw = tab_main[i]; hit = 1; end
      end
      a_sn = fast ? sn_f : sn;
      a_ck = fast ? cken_f : cken;
      a_bz = fast ? busy_f : busy;
      a_dn = fast ? done_f : done;
      chk($sformatf("%s sn t+%0d", tag, k), 32'(a_sn), 32'(rw.sn));
      chk($sformatf("%s cken t+%0d", tag, k), 32'(a_ck), 32'(rw.cken));
      chk($sformatf("%s busy t+%0d", tag, k), 32'(a_bz), 32'(rw.busy));
      chk($sformatf("%s done t+%0d", tag, k), 32'(a_dn), 32'(rw.done));
      if (k == x1 || k == x2) begin
        if (fast) start_f = 1'b1; else start = 1'b1;
      end
      step();
      start = 1'b0;
      start_f = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  k;
    bit  done_seen;

    tab_main[0]  = '{ 1,  1, 4'b1111, 1'b0, 1'b1, 1'b0};
    tab_main[1]  = '{ 2,  4, 4'b1110, 1'b0, 1'b1, 1'b0};
    tab_main[2]  = '{ 5,  6, 4'b1111, 1'b0, 1'b1, 1'b0};
    tab_main[3]  = '{ 7,  9, 4'b1101, 1'b0, 1'b1, 1'b0};
    tab_main[4]  = '{10, 11, 4'b1111, 1'b0, 1'b1, 1'b0};
    tab_main[5]  = '{12, 14, 4'b1011, 1'b0, 1'b1, 1'b0};
    tab_main[6]  = '{15, 16, 4'b1111, 1'b0, 1'b1, 1'b0};
    tab_main[7]  = '{17, 19, 4'b0111, 1'b0, 1'b1, 1'b0};
    tab_main[8]  = '{20, 20, 4'b1111, 1'b0, 1'b1, 1'b0};
    tab_main[9]  = '{21, 21, 4'b1111, 1'b1, 1'b0, 1'b1};
    tab_main[10] = '{22, 24, 4'b1111, 1'b1, 1'b0, 1'b0};

    tab_fast[0]  = '{1, 1, 4'b1111, 1'b0, 1'b1, 1'b0};
    tab_fast[1]  = '{2, 2, 4'b1110, 1'b0, 1'b1, 1'b0};
    tab_fast[2]  = '{3, 3, 4'b1101, 1'b0, 1'b1, 1'b0};
    tab_fast[3]  = '{4, 4, 4'b1011, 1'b0, 1'b1, 1'b0};
    tab_fast[4]  = '{5, 5, 4'b0111, 1'b0, 1'b1, 1'b0};
    tab_fast[5]  = '{6, 6, 4'b1111, 1'b0, 1'b1, 1'b0};
    tab_fast[6]  = '{7, 7, 4'b1111, 1'b1, 1'b0, 1'b1};
    tab_fast[7]  = '{8, 9, 4'b1111, 1'b1, 1'b0, 1'b0};

    r = 1'b1; start = 1'b0; start_f = 1'b0;
`ifdef DFFSN_PRESET_SEQ_MASK_EN
    mask = 4'hF;
`endif

    // 1: reset values
    step(); step();
    r = 1'b0;
    chk("reset sn", 32'(sn), 32'hF);
    chk("reset cken", 32'(cken), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset state", 32'(st), 32'd0);
    step();
    chk("idle sn", 32'(sn), 32'hF);
    chk("idle cken", 32'(cken), 32'd1);

    // 2: full default sequence
    run_table(1'b0, 24, -1, -1, "seq");
    // 3: START at t+8 (busy) and t+21 (FIN) must be ignored
    run_table(1'b0, 24, 8, 21, "ign");

    // 4: reset during group 1's pulse, then restart
    pulse_start(1'b0);
    for (int i = 1; i < 7; i++) step();
    chk("abort pre sn", 32'(sn), 32'b1101);
    r = 1'b1;
    step();
    r = 1'b0;
    chk("abort sn", 32'(sn), 32'hF);
    chk("abort cken", 32'(cken), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    done_seen = 0;
    step();
    done_seen = done_seen | done;
    chk("abort idle busy", 32'(busy), 32'd0);
    chk("abort no done", 32'(done_seen), 32'd0);
    pulse_start(1'b0);
    chk("restart cken", 32'(cken), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    step();
    chk("restart sn g0", 32'(sn), 32'b1110);
    k = 2;
    while (!done && k < 40) begin
      step();
      k++;
    end
    chk("restart done cycle", 32'(k), 32'd21);

    // 5: PW=1, GAP=0 build
    step();
    run_table(1'b1, 9, -1, -1, "fast");

`ifdef DFFSN_PRESET_SEQ_MASK_EN
    // 6: masked runs
    mask = 4'b1010;
    pulse_start(1'b0);
    mask = 4'b0101;
    for (int i = 2; i <= 11; i++) begin
      step();
      if (i >= 2 && i <= 4) chk($sformatf("mask sn t+%0d", i), 32'(sn), 32'b1101);
      else if (i >= 7 && i <= 9) chk($sformatf("mask sn t+%0d", i), 32'(sn), 32'b0111);
      else chk($sformatf("mask sn t+%0d", i), 32'(sn), 32'hF);
    end
    chk("mask done t+11", 32'(done), 32'd1);
    step();
    mask = 4'b0000;
    pulse_start(1'b0);
    step();
    chk("mask0 post t+2", 32'({cken, busy, done}), 32'b010);
    step();
    chk("mask0 done t+3", 32'({cken, busy, done}), 32'b101);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
